// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings, IDs and widths for the memory arbiter
package mem_arbiter_pkg;

  localparam int ADDR_WID       = 32;
  localparam int DATA_WID       = 32;
  localparam int MC_LEN_WID     = 7;
  localparam int LINE_BYTES_DEF = 64;
  localparam int MAX_STREAK_DEF = 4;

  localparam int NUM_REQ = 3;
  localparam int REQ_IF  = 0;
  localparam int REQ_LD  = 1;
  localparam int REQ_ST  = 2;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_IF,
    ARB_LD,
    ARB_ST,
    ARB_DRAIN
  } arb_state_t;

endpackage

// File: rtl/arb_priority_pick.sv
// rtl/arb_priority_pick.sv - one-hot grant: ST > LD > IF, IF forced once the streak saturates
module arb_priority_pick
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               streak_sat,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    if (streak_sat && req[REQ_IF]) grant[REQ_IF] = 1'b1;
    else if (req[REQ_ST])          grant[REQ_ST] = 1'b1;
    else if (req[REQ_LD])          grant[REQ_LD] = 1'b1;
    else if (req[REQ_IF])          grant[REQ_IF] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory controller port between line fetch, load and store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LINE_BYTES = LINE_BYTES_DEF,
  parameter int MAX_STREAK = MAX_STREAK_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    if_req,
  input  logic [ADDR_WID-1:0]     if_addr,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_line,
  input  logic                    ld_req,
  input  logic [ADDR_WID-1:0]     ld_addr,
  input  logic [2:0]              ld_len,
  output logic                    ld_done,
  output logic [DATA_WID-1:0]     ld_data,
  input  logic                    st_req,
  input  logic [ADDR_WID-1:0]     st_addr,
  input  logic [2:0]              st_len,
  input  logic [DATA_WID-1:0]     st_data,
  output logic                    st_done,
  output logic                    mc_en,
  output logic                    mc_wr,
  output logic                    mc_is_if,
  output logic [ADDR_WID-1:0]     mc_addr,
  output logic [MC_LEN_WID-1:0]   mc_len,
  output logic [DATA_WID-1:0]     mc_wdata,
  input  logic                    mc_done,
  input  logic [DATA_WID-1:0]     mc_rdata,
  input  logic [LINE_BYTES*8-1:0] mc_line
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);

  arb_state_t state, state_d;
  logic [STREAK_W-1:0] streak, streak_d;
  logic [NUM_REQ-1:0]  grant;
  logic                streak_sat;

  logic                    if_done_d, ld_done_d, st_done_d;
  logic [LINE_BYTES*8-1:0] if_line_d;
  logic [DATA_WID-1:0]     ld_data_d;
  logic                    mc_en_d, mc_wr_d, mc_is_if_d;
  logic [ADDR_WID-1:0]     mc_addr_d;
  logic [MC_LEN_WID-1:0]   mc_len_d;
  logic [DATA_WID-1:0]     mc_wdata_d;

  assign streak_sat = (streak == STREAK_W'(MAX_STREAK));

  arb_priority_pick u_pick (
    .req        ({st_req, ld_req, if_req}),
    .streak_sat (streak_sat),
    .grant      (grant)
  );

  always_comb begin
    state_d    = state;
    streak_d   = streak;
    if_done_d  = if_done;
    ld_done_d  = ld_done;
    st_done_d  = st_done;
    if_line_d  = if_line;
    ld_data_d  = ld_data;
    mc_en_d    = mc_en;
    mc_wr_d    = mc_wr;
    mc_is_if_d = mc_is_if;
    mc_addr_d  = mc_addr;
    mc_len_d   = mc_len;
    mc_wdata_d = mc_wdata;

    case (state)
      ARB_IDLE: begin
        if (!if_req) streak_d = '0;
        // A done pulse from last cycle costs one idle turnaround before the next grant
        if (if_done || ld_done || st_done) begin
          if_done_d = 1'b0;
          ld_done_d = 1'b0;
          st_done_d = 1'b0;
        end else if (!rollback && (grant != '0)) begin
          mc_en_d = 1'b1;
          if (grant[REQ_IF]) begin
            mc_wr_d    = 1'b0;
            mc_is_if_d = 1'b1;
            mc_addr_d  = if_addr;
            mc_len_d   = MC_LEN_WID'(LINE_BYTES);
            mc_wdata_d = '0;
            streak_d   = '0;
            state_d    = ARB_IF;
          end else begin
            if (if_req && !streak_sat) streak_d = streak + STREAK_W'(1);
            mc_is_if_d = 1'b0;
            if (grant[REQ_ST]) begin
              mc_wr_d    = 1'b1;
              mc_addr_d  = st_addr;
              mc_len_d   = MC_LEN_WID'(st_len);
              mc_wdata_d = st_data;
              state_d    = ARB_ST;
            end else begin
              mc_wr_d    = 1'b0;
              mc_addr_d  = ld_addr;
              mc_len_d   = MC_LEN_WID'(ld_len);
              mc_wdata_d = '0;
              state_d    = ARB_LD;
            end
          end
        end
      end
      ARB_IF, ARB_LD: begin
        if (rollback) begin
          if (mc_done) begin
            mc_en_d = 1'b0;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_DRAIN;
          end
        end else if (mc_done) begin
          mc_en_d = 1'b0;
          state_d = ARB_IDLE;
          if (state == ARB_IF) begin
            if_done_d = 1'b1;
            if_line_d = mc_line;
          end else begin
            ld_done_d = 1'b1;
            ld_data_d = mc_rdata;
          end
        end
      end
      ARB_ST: begin
        // Stores are already committed, so rollback does not cancel them
        if (mc_done) begin
          mc_en_d   = 1'b0;
          st_done_d = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      ARB_DRAIN: begin
        if (mc_done) begin
          mc_en_d = 1'b0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        mc_en_d = 1'b0;
        state_d = ARB_IDLE;
      end
    endcase

    if (rollback) streak_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      streak   <= '0;
      if_done  <= 1'b0;
      ld_done  <= 1'b0;
      st_done  <= 1'b0;
      if_line  <= '0;
      ld_data  <= '0;
      mc_en    <= 1'b0;
      mc_wr    <= 1'b0;
      mc_is_if <= 1'b0;
      mc_addr  <= '0;
      mc_len   <= '0;
      mc_wdata <= '0;
    end else if (rdy) begin
      state    <= state_d;
      streak   <= streak_d;
      if_done  <= if_done_d;
      ld_done  <= ld_done_d;
      st_done  <= st_done_d;
      if_line  <= if_line_d;
      ld_data  <= ld_data_d;
      mc_en    <= mc_en_d;
      mc_wr    <= mc_wr_d;
      mc_is_if <= mc_is_if_d;
      mc_addr  <= mc_addr_d;
      mc_len   <= mc_len_d;
      mc_wdata <= mc_wdata_d;
    end
  end

endmodule
